// File: rtl/icache_nway_refill.sv
// N-way set-associative read-only instruction cache with counted-burst line refill,
// invalid-first / per-set round-robin replacement and a whole-cache invalidate sweep.
module icache_nway_refill #(
  parameter int OFFSET_LEN = 5,
  parameter int INDEX_LEN  = 7,
  parameter int WAY_CNT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        miss,
  input  logic        inv_all,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int TAG_LEN    = 32 - INDEX_LEN - OFFSET_LEN;
  localparam int LINE_WORDS = 2 ** (OFFSET_LEN - 2);
  localparam int SETS       = 2 ** INDEX_LEN;
  localparam int WAY_W      = $clog2(WAY_CNT);
  localparam int CNT_W      = OFFSET_LEN - 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_FILL   = 2'd2;
  localparam logic [1:0] S_INVAL  = 2'd3;

  logic [TAG_LEN-1:0] tag_mem  [WAY_CNT][SETS];
  logic [31:0]        data_mem [WAY_CNT][SETS][LINE_WORDS];
  logic [31:0]        linebuf  [LINE_WORDS];

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 inv_pending_q, inv_pending_d;
  logic [INDEX_LEN-1:0] inv_set_q, inv_set_d;
  logic [31:0]          line_addr_q, line_addr_d;
  logic [WAY_W-1:0]     victim_q, victim_d;
  logic                 victim_rr_q, victim_rr_d;
  logic [SETS-1:0]      valid_q [WAY_CNT];
  logic [SETS-1:0]      valid_d [WAY_CNT];
  logic [WAY_W-1:0]     rr_q [SETS];
  logic [WAY_W-1:0]     rr_d [SETS];

  logic [TAG_LEN-1:0]   req_tag;
  logic [INDEX_LEN-1:0] req_idx;
  logic [CNT_W-1:0]     req_word;
  logic [INDEX_LEN-1:0] fill_idx;
  logic [TAG_LEN-1:0]   fill_tag;
  logic [WAY_CNT-1:0]   hit_vec;
  logic                 hit;
  logic [WAY_W-1:0]     hit_way;
  logic [WAY_W-1:0]     vict_way;
  logic                 vict_rr;
  logic                 unused_addr_bits;

  assign req_tag          = cpu_addr[31 -: TAG_LEN];
  assign req_idx          = cpu_addr[OFFSET_LEN +: INDEX_LEN];
  assign req_word         = cpu_addr[2 +: CNT_W];
  assign fill_idx         = line_addr_q[OFFSET_LEN +: INDEX_LEN];
  assign fill_tag         = line_addr_q[31 -: TAG_LEN];
  assign unused_addr_bits = ^cpu_addr[1:0];

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAY_CNT; w++) begin
      hit_vec[w] = valid_q[w][req_idx] && (tag_mem[w][req_idx] == req_tag);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  assign hit       = |hit_vec;
  assign cpu_ready = cpu_req && hit && (state_q == S_IDLE);
  assign cpu_rdata = cpu_ready ? data_mem[hit_way][req_idx][req_word] : 32'd0;
  assign miss      = cpu_req && !cpu_ready;
  assign mem_req   = (state_q == S_REFILL);
  assign mem_addr  = line_addr_q;

  // Lowest-numbered invalid way wins; round-robin only when the set is full.
  always_comb begin
    vict_way = rr_q[req_idx];
    vict_rr  = 1'b1;
    for (int w = WAY_CNT - 1; w >= 0; w--) begin
      if (!valid_q[w][req_idx]) begin
        vict_way = WAY_W'(w);
        vict_rr  = 1'b0;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    inv_pending_d = inv_pending_q;
    inv_set_d     = inv_set_q;
    line_addr_d   = line_addr_q;
    victim_d      = victim_q;
    victim_rr_d   = victim_rr_q;
    valid_d       = valid_q;
    rr_d          = rr_q;
    case (state_q)
      S_IDLE: begin
        if (inv_all || inv_pending_q) begin
          state_d   = S_INVAL;
          inv_set_d = '0;
        end else if (cpu_req && !hit) begin
          state_d     = S_REFILL;
          cnt_d       = '0;
          line_addr_d = {cpu_addr[31:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
          victim_d    = vict_way;
          victim_rr_d = vict_rr;
        end
      end
      S_REFILL: begin
        if (mem_rvalid) begin
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) begin
            state_d = S_FILL;
            cnt_d   = '0;
          end
        end
      end
      S_FILL: begin
        valid_d[victim_q][fill_idx] = 1'b1;
        if (victim_rr_q) rr_d[fill_idx] = rr_q[fill_idx] + 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        for (int w = 0; w < WAY_CNT; w++) valid_d[w][inv_set_q] = 1'b0;
        inv_set_d     = inv_set_q + 1'b1;
        inv_pending_d = 1'b0;
        if (&inv_set_q) state_d = S_IDLE;
      end
    endcase
    // An invalidate that arrives while busy is remembered and run from IDLE.
    if (inv_all && (state_q != S_IDLE)) inv_pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      inv_pending_q <= 1'b0;
      inv_set_q     <= '0;
      line_addr_q   <= '0;
      victim_q      <= '0;
      victim_rr_q   <= 1'b0;
      for (int w = 0; w < WAY_CNT; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      inv_pending_q <= inv_pending_d;
      inv_set_q     <= inv_set_d;
      line_addr_q   <= line_addr_d;
      victim_q      <= victim_d;
      victim_rr_q   <= victim_rr_d;
      valid_q       <= valid_d;
      rr_q          <= rr_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by valid_q alone.
  always_ff @(posedge clk) begin
    if ((state_q == S_REFILL) && mem_rvalid) linebuf[cnt_q] <= mem_rdata;
    if (state_q == S_FILL) begin
      tag_mem[victim_q][fill_idx] <= fill_tag;
      for (int i = 0; i < LINE_WORDS; i++) data_mem[victim_q][fill_idx][i] <= linebuf[i];
    end
  end

  a_single_hit: assert property (@(posedge clk) disable iff (rst) $onehot0(hit_vec));

endmodule
